// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner: drives one digit at a time with
// dead time between digits and swaps in new frames only at frame boundaries.
module seg7_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    input  logic [5*NUM_DIGITS-1:0] upd_data,
    output logic                    upd_ready,
    output logic [4:0]              code,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(CLK_DIV);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LIM  = SLOT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [4:0]        CODE_BLANK = 5'd31;

    logic [SLOT_W-1:0]          slot_cnt;
    logic [DIG_W-1:0]           dig_idx;
    logic [NUM_DIGITS-1:0][4:0] active;
    logic [NUM_DIGITS-1:0][4:0] pending;
    logic                       pending_full;

    logic                       slot_end;
    logic                       frame_end;
    logic                       take;

    logic                       lit_p0;
    logic [NUM_DIGITS-1:0]      an_p0;
    logic [4:0]                 code_p0;

    // Active-low anode pattern selecting exactly one digit.
    function automatic logic [NUM_DIGITS-1:0] anode_mask(input logic [DIG_W-1:0] idx);
        logic [NUM_DIGITS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return ~(one << idx);
    endfunction

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (dig_idx == DIG_LAST);
    assign upd_ready = ~pending_full;
    assign take      = upd_valid && upd_ready;

    // Slot counter and digit index; digit advances on each slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DIG_W'(1);
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Pending slot flag and the displayed frame; a waiting frame is
    // promoted only on the frame-end edge so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_full <= 1'b0;
            active       <= '1;
        end else if (frame_end && pending_full) begin
            pending_full <= 1'b0;
            active       <= pending;
        end else if (take) begin
            pending_full <= 1'b1;
        end
    end

    // Pending frame storage; only the full flag needs a reset.
    always_ff @(posedge clk) begin
        if (take) begin
            pending <= upd_data;
        end
    end

    // Stage p0: decide blank vs lit for the current slot position.
    always_comb begin
        lit_p0  = 1'b0;
        an_p0   = '1;
        code_p0 = CODE_BLANK;
        if (slot_cnt >= BLANK_LIM) begin
            lit_p0  = 1'b1;
            an_p0   = anode_mask(dig_idx);
            code_p0 = active[dig_idx];
        end
    end

    // Stage p1: registered outputs, one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            code       <= CODE_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= lit_p0 ? an_p0 : '1;
            code       <= code_p0;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed testbench for seg7_scan with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * CD;

    localparam logic [19:0] BLANKF = {4{5'd31}};
    localparam logic [19:0] F1     = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [19:0] FA     = {5'd13, 5'd12, 5'd11, 5'd10};
    localparam logic [19:0] FB     = {5'd30, 5'd25, 5'd21, 5'd20};
    localparam logic [19:0] FC     = {5'd15, 5'd14, 5'd13, 5'd12};
    localparam logic [19:0] FD     = {5'd19, 5'd18, 5'd17, 5'd16};
    localparam logic [19:0] FE     = {5'd20, 5'd16, 5'd8, 5'd0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic [19:0] upd_data = '0;
    logic        upd_ready;
    logic [4:0]  code;
    logic [3:0]  an_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .NUM_DIGITS(ND),
        .CLK_DIV(CD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .upd_valid(upd_valid),
        .upd_data(upd_data),
        .upd_ready(upd_ready),
        .code(code),
        .an_n(an_n),
        .frame_tick(frame_tick)
    );

    // cyc counts rising edges since reset release; sample 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Output after edge c reflects counter state (c-1).
    function automatic logic [3:0] exp_an(input int c);
        int s, d;
        s = (c - 1) % CD;
        d = ((c - 1) / CD) % ND;
        if (s < BC) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [4:0] exp_code(input int c, input logic [19:0] fr);
        int s, d;
        s = (c - 1) % CD;
        d = ((c - 1) / CD) % ND;
        if (s < BC) return 5'd31;
        return fr[d*5 +: 5];
    endfunction

    function automatic logic exp_ft(input int c);
        return (c > 0) && (((c - 1) % FRAME) == FRAME - 1);
    endfunction

    task automatic test_reset;
        #12;
        checks++;
        if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an_n got=%b exp=1111", an_n); end
        checks++;
        if (code !== 5'd31) begin errors++; $display("FAIL reset_code got=%0d exp=31", code); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        checks++;
        if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_upd_ready got=%b exp=1", upd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_idle_scan;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (an_n !== exp_an(cyc) || code !== 5'd31 || frame_tick !== exp_ft(cyc) || upd_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_scan cyc=%0d got an_n=%b code=%0d ft=%b rdy=%b exp an_n=%b code=31 ft=%b rdy=1",
                         cyc, an_n, code, frame_tick, upd_ready, exp_an(cyc), exp_ft(cyc));
            end
        end
    endtask

    task automatic test_update;
        while (cyc < 70) tick();
        checks++;
        if (upd_ready !== 1'b1) begin errors++; $display("FAIL update_ready_before got=%b exp=1", upd_ready); end
        upd_valid = 1'b1;
        upd_data  = F1;
        tick();
        upd_valid = 1'b0;
        upd_data  = 20'hABCDE;
        checks++;
        if (upd_ready !== 1'b0) begin errors++; $display("FAIL update_ready_drop got=%b exp=0", upd_ready); end
        while (cyc < 2 * FRAME + FRAME - 1) begin
            tick();
            checks++;
            if (upd_ready !== 1'b0 || code !== 5'd31) begin
                errors++;
                $display("FAIL update_wait cyc=%0d got rdy=%b code=%0d exp rdy=0 code=31", cyc, upd_ready, code);
            end
        end
        tick();
        checks++;
        if (upd_ready !== 1'b1 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL update_copy cyc=%0d got rdy=%b ft=%b exp rdy=1 ft=1", cyc, upd_ready, frame_tick);
        end
        repeat (FRAME) begin
            tick();
            checks++;
            if (an_n !== exp_an(cyc) || code !== exp_code(cyc, F1)) begin
                errors++;
                $display("FAIL update_show cyc=%0d got an_n=%b code=%0d exp an_n=%b code=%0d",
                         cyc, an_n, code, exp_an(cyc), exp_code(cyc, F1));
            end
        end
    endtask

    task automatic test_back_to_back;
        while (cyc < 130) tick();
        upd_valid = 1'b1;
        upd_data  = FA;
        tick();
        upd_data  = FB;
        checks++;
        if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_a_accept got rdy=%b exp=0", upd_ready); end
        while (cyc < 5 * FRAME - 1) begin
            tick();
            checks++;
            if (upd_ready !== 1'b0 || code !== exp_code(cyc, F1)) begin
                errors++;
                $display("FAIL b2b_stall cyc=%0d got rdy=%b code=%0d exp rdy=0 code=%0d",
                         cyc, upd_ready, code, exp_code(cyc, F1));
            end
        end
        tick();
        checks++;
        if (upd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise cyc=%0d got=%b exp=1", cyc, upd_ready); end
        tick();
        upd_valid = 1'b0;
        upd_data  = 20'h5A5A5;
        checks++;
        if (upd_ready !== 1'b0 || code !== exp_code(cyc, FA)) begin
            errors++;
            $display("FAIL b2b_b_accept cyc=%0d got rdy=%b code=%0d exp rdy=0 code=%0d",
                     cyc, upd_ready, code, exp_code(cyc, FA));
        end
        while (cyc < 6 * FRAME - 1) begin
            tick();
            checks++;
            if (an_n !== exp_an(cyc) || code !== exp_code(cyc, FA) || upd_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_show_a cyc=%0d got an_n=%b code=%0d rdy=%b exp an_n=%b code=%0d rdy=0",
                         cyc, an_n, code, upd_ready, exp_an(cyc), exp_code(cyc, FA));
            end
        end
        tick();
        checks++;
        if (upd_ready !== 1'b1) begin errors++; $display("FAIL b2b_copy_b cyc=%0d got rdy=%b exp=1", cyc, upd_ready); end
        repeat (FRAME) begin
            tick();
            checks++;
            if (an_n !== exp_an(cyc) || code !== exp_code(cyc, FB)) begin
                errors++;
                $display("FAIL b2b_show_b cyc=%0d got an_n=%b code=%0d exp an_n=%b code=%0d",
                         cyc, an_n, code, exp_an(cyc), exp_code(cyc, FB));
            end
        end
    endtask

    task automatic test_boundary_offer;
        while (cyc < 8 * FRAME - 1) tick();
        upd_valid = 1'b1;
        upd_data  = FC;
        tick();
        upd_valid = 1'b0;
        upd_data  = '0;
        checks++;
        if (upd_ready !== 1'b0 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL boundary_accept cyc=%0d got rdy=%b ft=%b exp rdy=0 ft=1", cyc, upd_ready, frame_tick);
        end
        while (cyc < 9 * FRAME - 1) begin
            tick();
            checks++;
            if (code !== exp_code(cyc, FB) || upd_ready !== 1'b0) begin
                errors++;
                $display("FAIL boundary_hold cyc=%0d got code=%0d rdy=%b exp code=%0d rdy=0",
                         cyc, code, upd_ready, exp_code(cyc, FB));
            end
        end
        tick();
        checks++;
        if (upd_ready !== 1'b1) begin errors++; $display("FAIL boundary_copy cyc=%0d got rdy=%b exp=1", cyc, upd_ready); end
        repeat (FRAME) begin
            tick();
            checks++;
            if (an_n !== exp_an(cyc) || code !== exp_code(cyc, FC)) begin
                errors++;
                $display("FAIL boundary_show cyc=%0d got an_n=%b code=%0d exp an_n=%b code=%0d",
                         cyc, an_n, code, exp_an(cyc), exp_code(cyc, FC));
            end
        end
    endtask

    task automatic test_reset_mid;
        while (cyc < 322) tick();
        upd_valid = 1'b1;
        upd_data  = FD;
        tick();
        upd_valid = 1'b0;
        checks++;
        if (upd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_accept got rdy=%b exp=0", upd_ready); end
        while (cyc < 332) tick();
        checks++;
        if (an_n !== 4'b1101 || code !== 5'd13) begin
            errors++;
            $display("FAIL rstmid_pre got an_n=%b code=%0d exp an_n=1101 code=13", an_n, code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an_n !== 4'hF || code !== 5'd31 || upd_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got an_n=%b code=%0d rdy=%b ft=%b exp an_n=1111 code=31 rdy=1 ft=0",
                     an_n, code, upd_ready, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (an_n !== exp_an(cyc) || code !== 5'd31 || upd_ready !== 1'b1 || frame_tick !== exp_ft(cyc)) begin
                errors++;
                $display("FAIL rstmid_after cyc=%0d got an_n=%b code=%0d rdy=%b ft=%b exp an_n=%b code=31 rdy=1 ft=%b",
                         cyc, an_n, code, upd_ready, frame_tick, exp_an(cyc), exp_ft(cyc));
            end
        end
    endtask

    task automatic test_invariants;
        while (cyc < 66) tick();
        upd_valid = 1'b1;
        upd_data  = FE;
        tick();
        upd_valid = 1'b0;
        while (cyc < 3 * FRAME) tick();
        repeat (4 * FRAME) begin
            tick();
            checks++;
            if ($countones(~an_n) > 1 || ((code == 5'd31) != (an_n == 4'hF))) begin
                errors++;
                $display("FAIL invariant cyc=%0d got an_n=%b code=%0d", cyc, an_n, code);
            end
            checks++;
            if (an_n !== exp_an(cyc) || code !== exp_code(cyc, FE)) begin
                errors++;
                $display("FAIL inv_show cyc=%0d got an_n=%b code=%0d exp an_n=%b code=%0d",
                         cyc, an_n, code, exp_an(cyc), exp_code(cyc, FE));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_update();
        test_back_to_back();
        test_boundary_offer();
        test_reset_mid();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
